// File: rtl/srcnn_mul_rr_sched.sv
// ---------------------------------------------------------------------------
// srcnn_mul_rr_sched
//
// Shares a single combinational unsigned multiplier between NUM_REQ
// requesters. A round-robin arbiter picks one valid requester per cycle. Its
// operands are registered onto the multiplier inputs (stage S1). The product
// is captured into the result register (stage S2). The result is then
// returned to the requester that issued it, over a one-hot valid/ready
// response channel.
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst_n   in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]           per-requester operand valid
//   req_ready  out  [NUM_REQ]           per-requester accept (at most one set)
//   req_a      in   [NUM_REQ*A_WIDTH]   operand A, requester i at [i*A_WIDTH +: A_WIDTH]
//   req_b      in   [NUM_REQ*B_WIDTH]   operand B, requester i at [i*B_WIDTH +: B_WIDTH]
//   mul_din0   out  [A_WIDTH]           registered multiplier operand A
//   mul_din1   out  [B_WIDTH]           registered multiplier operand B
//   mul_dout   in   [P_WIDTH]           combinational multiplier product
//   rsp_valid  out  [NUM_REQ]           one-hot result valid for the owner
//   rsp_ready  in   [NUM_REQ]           per-requester result accept
//   rsp_data   out  [P_WIDTH]           product, qualified by rsp_valid
// ---------------------------------------------------------------------------
module srcnn_mul_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int A_WIDTH = 5,
    parameter int B_WIDTH = 66,
    parameter int P_WIDTH = 69
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic [A_WIDTH-1:0]           mul_din0,
    output logic [B_WIDTH-1:0]           mul_din1,
    input  logic [P_WIDTH-1:0]           mul_dout,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [P_WIDTH-1:0]           rsp_data
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      rr_next;
    logic [IW-1:0]      grant_idx;
    logic [IW:0]        cand_sum;
    logic               grant_any;
    logic               op_vld;
    logic [IW-1:0]      op_owner;
    logic               res_vld;
    logic [IW-1:0]      res_owner;
    logic               adv1;
    logic               adv2;
    logic               xfer;
    logic [A_WIDTH-1:0] sel_a;
    logic [B_WIDTH-1:0] sel_b;

    // Round-robin search: candidates are visited starting at rr_ptr and
    // wrapping modulo NUM_REQ; the first valid one wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand_sum >= (IW+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IW+1)'(NUM_REQ);
            end
            if (!grant_any && req_valid[cand_sum[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand_sum[IW-1:0];
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_a = req_a[i*A_WIDTH +: A_WIDTH];
                sel_b = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // S2 may take new data when it is empty or its owner drains it this
    // cycle. S1 may take new data when it is empty or moves into S2.
    // req_ready is held low while reset is asserted so that nothing appears
    // accepted during reset.
    always_comb begin
        adv2      = !res_vld || rsp_ready[res_owner];
        adv1      = !op_vld || adv2;
        req_ready = (ap_rst_n && adv1 && grant_any) ? (NUM_REQ'(1) << grant_idx) : '0;
        xfer      = ap_rst_n && adv1 && grant_any;
        rr_next   = (grant_idx == IW'(NUM_REQ-1)) ? '0 : grant_idx + IW'(1);
        rsp_valid = res_vld ? (NUM_REQ'(1) << res_owner) : '0;
    end

    // Two-stage pipeline and arbitration pointer. The operand registers keep
    // their last value when S1 empties. Only op_vld clears.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr    <= '0;
            op_vld    <= 1'b0;
            op_owner  <= '0;
            mul_din0  <= '0;
            mul_din1  <= '0;
            res_vld   <= 1'b0;
            res_owner <= '0;
            rsp_data  <= '0;
        end else begin
            if (xfer) begin
                op_vld   <= 1'b1;
                op_owner <= grant_idx;
                mul_din0 <= sel_a;
                mul_din1 <= sel_b;
                rr_ptr   <= rr_next;
            end else if (adv1) begin
                op_vld <= 1'b0;
            end

            if (adv2) begin
                if (op_vld) begin
                    res_vld   <= 1'b1;
                    res_owner <= op_owner;
                    rsp_data  <= mul_dout;
                end else begin
                    res_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_srcnn_mul_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_srcnn_mul_rr_sched
//
// Directed bench for the round-robin multiplier scheduler. The bench supplies
// the external multiplier. It uses a full-precision product width of
// A_WIDTH+B_WIDTH, so products are never truncated. Each scenario task drives
// its own stimulus and checks its own results. Inputs change 1 time unit
// after a rising edge. Outputs are sampled 1 time unit later, well before the
// next rising edge.
// ---------------------------------------------------------------------------
module tb_srcnn_mul_rr_sched;

    localparam int NR = 4;
    localparam int AW = 5;
    localparam int BW = 66;
    localparam int PW = AW + BW;

    logic                ap_clk;
    logic                ap_rst_n;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0]       req_ready;
    logic [NR*AW-1:0]    req_a;
    logic [NR*BW-1:0]    req_b;
    logic [AW-1:0]       mul_din0;
    logic [BW-1:0]       mul_din1;
    logic [PW-1:0]       mul_dout;
    logic [NR-1:0]       rsp_valid;
    logic [NR-1:0]       rsp_ready;
    logic [PW-1:0]       rsp_data;

    int n_checks;
    int n_fail;

    typedef struct {
        int          owner;
        logic [PW-1:0] prod;
        int          stage;
    } item_t;

    item_t sb[$];

    srcnn_mul_rr_sched #(
        .NUM_REQ(NR),
        .A_WIDTH(AW),
        .B_WIDTH(BW),
        .P_WIDTH(PW)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    // The shared combinational multiplier.
    assign mul_dout = PW'(mul_din0) * PW'(mul_din1);

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    function automatic logic [PW-1:0] mulp(input logic [AW-1:0] a, input logic [BW-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (ptr + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int g);
        logic [NR-1:0] e;
        e = '0;
        if (g >= 0) e[g] = 1'b1;
        return e;
    endfunction

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        req_a[i*AW +: AW] = a;
        req_b[i*BW +: BW] = b;
    endtask

    task automatic reset_dut();
        ap_rst_n  = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        step();
        step();
        ap_rst_n = 1'b1;
    endtask

    // Outputs are zero while reset is held, even with every requester valid.
    task automatic test_reset();
        ap_rst_n  = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        req_a     = '1;
        req_b     = '1;
        step();
        n_checks++;
        if (req_ready !== '0) begin
            n_fail++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        n_checks++;
        if (rsp_valid !== '0) begin
            n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", rsp_valid);
        end
        n_checks++;
        if (rsp_data !== '0) begin
            n_fail++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data);
        end
        n_checks++;
        if (mul_din0 !== '0) begin
            n_fail++; $display("[TB] FAIL reset_mul_din0: got %h expected 0", mul_din0);
        end
        n_checks++;
        if (mul_din1 !== '0) begin
            n_fail++; $display("[TB] FAIL reset_mul_din1: got %h expected 0", mul_din1);
        end
        req_valid = '0;
        step();
        ap_rst_n = 1'b1;
    endtask

    // Requester 0 with extreme operands; result appears two edges after accept.
    task automatic test_single();
        logic [PW-1:0] exp_p;
        exp_p = 71'h7B_FFFF_FFFF_FFFF_FFE1;
        reset_dut();
        rsp_ready = '1;
        set_op(0, 5'd31, {BW{1'b1}});
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("[TB] FAIL single_ready: got %b expected 0001", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        n_checks++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL single_early_valid: got %b expected 0000", rsp_valid);
        end
        n_checks++;
        if (mul_din0 !== 5'd31 || mul_din1 !== {BW{1'b1}}) begin
            n_fail++; $display("[TB] FAIL single_operands: got %h/%h expected 1f/all-ones", mul_din0, mul_din1);
        end
        step();
        n_checks++;
        if (rsp_valid !== 4'b0001) begin
            n_fail++; $display("[TB] FAIL single_rsp_valid: got %b expected 0001", rsp_valid);
        end
        n_checks++;
        if (rsp_data !== exp_p) begin
            n_fail++; $display("[TB] FAIL single_rsp_data: got %h expected %h", rsp_data, exp_p);
        end
        step();
        n_checks++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL single_drained: got %b expected 0000", rsp_valid);
        end
    endtask

    // All four valid continuously: grants rotate 0,1,2,3,0,... with one
    // product per cycle.
    task automatic test_fairness();
        int            exp_g[10];
        logic [PW-1:0] exp_p[10];
        reset_dut();
        rsp_ready = '1;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NR; i++) begin
                set_op(i, AW'(c*4 + i + 1), BW'(1000 + c*10 + i));
            end
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                exp_g[c] = c % NR;
                exp_p[c] = mulp(AW'(c*4 + exp_g[c] + 1), BW'(1000 + c*10 + exp_g[c]));
                n_checks++;
                if (req_ready !== onehot(exp_g[c])) begin
                    n_fail++; $display("[TB] FAIL fair_grant c=%0d: got %b expected %b", c, req_ready, onehot(exp_g[c]));
                end
            end
            if (c >= 2) begin
                n_checks++;
                if (rsp_valid !== onehot(exp_g[c-2]) || rsp_data !== exp_p[c-2]) begin
                    n_fail++; $display("[TB] FAIL fair_rsp c=%0d: got %b/%h expected %b/%h", c, rsp_valid, rsp_data, onehot(exp_g[c-2]), exp_p[c-2]);
                end
            end
            step();
        end
        req_valid = '0;
    endtask

    // Requester 1 streams five products while its result port stalls.
    task automatic test_backpressure();
        int            sent;
        int            recvd;
        logic [PW-1:0] exp_bp[5];
        exp_bp = '{71'd2, 71'd6, 71'd12, 71'd20, 71'd30};
        sent  = 0;
        recvd = 0;
        for (int c = 0; c < 20; c++) begin
            rsp_ready = (c >= 1 && c <= 4) ? 4'b1101 : 4'b1111;
            if (sent < 5) begin
                set_op(1, AW'(sent + 1), BW'(sent + 2));
                req_valid = 4'b0010;
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (c >= 2 && c <= 4) begin
                n_checks++;
                if (req_ready !== 4'b0000) begin
                    n_fail++; $display("[TB] FAIL bp_stall_ready c=%0d: got %b expected 0000", c, req_ready);
                end
                n_checks++;
                if (rsp_valid !== 4'b0010 || rsp_data !== 71'd2) begin
                    n_fail++; $display("[TB] FAIL bp_stall_hold c=%0d: got %b/%0d expected 0010/2", c, rsp_valid, rsp_data);
                end
            end
            n_checks++;
            if ((rsp_valid & 4'b1101) !== 4'b0000) begin
                n_fail++; $display("[TB] FAIL bp_owner c=%0d: got %b expected only bit 1", c, rsp_valid);
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                n_checks++;
                if (recvd >= 5) begin
                    n_fail++; $display("[TB] FAIL bp_extra: got %0d results expected 5", recvd + 1);
                end else if (rsp_data !== exp_bp[recvd]) begin
                    n_fail++; $display("[TB] FAIL bp_data #%0d: got %0d expected %0d", recvd, rsp_data, exp_bp[recvd]);
                end
                recvd++;
            end
            if (req_valid[1] && req_ready[1]) sent++;
            step();
        end
        n_checks++;
        if (recvd !== 5) begin
            n_fail++; $display("[TB] FAIL bp_count: got %0d expected 5", recvd);
        end
    endtask

    // A lone grant to requester 0 leaves rr_ptr at 1. Then requesters 2 and 0
    // compete: expected grants are 2, 0, 2.
    task automatic test_skip();
        int            g[8];
        logic [PW-1:0] p[8];
        g = '{0, 2, 0, 2, -1, -1, -1, -1};
        rsp_ready = '1;
        for (int c = 0; c < 8; c++) begin
            set_op(0, AW'(c + 1), BW'(9));
            set_op(2, AW'(c + 10), BW'(5));
            req_valid = (c == 0) ? 4'b0001 : (c <= 3) ? 4'b0101 : 4'b0000;
            #1;
            p[c] = (g[c] == 0) ? mulp(AW'(c + 1), BW'(9)) : mulp(AW'(c + 10), BW'(5));
            n_checks++;
            if (req_ready !== onehot(g[c])) begin
                n_fail++; $display("[TB] FAIL skip_grant c=%0d: got %b expected %b", c, req_ready, onehot(g[c]));
            end
            if (c >= 2) begin
                n_checks++;
                if (rsp_valid !== onehot(g[c-2]) || (g[c-2] >= 0 && rsp_data !== p[c-2])) begin
                    n_fail++; $display("[TB] FAIL skip_rsp c=%0d: got %b/%0d expected %b/%0d", c, rsp_valid, rsp_data, onehot(g[c-2]), p[c-2]);
                end
            end
            step();
        end
    endtask

    // Reset asserted with two products in flight discards both.
    task automatic test_reset_mid();
        reset_dut();
        rsp_ready = '0;
        set_op(0, 5'd7, BW'(7));
        req_valid = 4'b0001;
        step();
        step();
        n_checks++;
        if (rsp_valid !== 4'b0001 || req_ready !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL rmid_full: got %b/%b expected 0001/0000", rsp_valid, req_ready);
        end
        #2;
        ap_rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== '0 || rsp_data !== '0 || req_ready !== '0) begin
            n_fail++; $display("[TB] FAIL rmid_outputs: got %b/%h/%b expected all zero", rsp_valid, rsp_data, req_ready);
        end
        n_checks++;
        if (mul_din0 !== '0 || mul_din1 !== '0) begin
            n_fail++; $display("[TB] FAIL rmid_operands: got %h/%h expected 0/0", mul_din0, mul_din1);
        end
        req_valid = '0;
        step();
        ap_rst_n  = 1'b1;
        rsp_ready = '1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (rsp_valid !== '0) begin
                n_fail++; $display("[TB] FAIL rmid_spurious c=%0d: got %b expected 0000", c, rsp_valid);
            end
        end
        set_op(3, 5'd2, BW'(3));
        req_valid = 4'b1000;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++; $display("[TB] FAIL rmid_regrant: got %b expected 1000", req_ready);
        end
        step();
        req_valid = '0;
        step();
        n_checks++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 71'd6) begin
            n_fail++; $display("[TB] FAIL rmid_result: got %b/%0d expected 1000/6", rsp_valid, rsp_data);
        end
    endtask

    // Random valid/ready/operands against a small pipeline and arbiter model.
    task automatic test_random();
        int            model_ptr;
        int            g;
        int            fo;
        logic          s1_full;
        logic          s2_full;
        logic          adv2m;
        logic          adv1m;
        logic [AW-1:0] ra[NR];
        logic [BW-1:0] rb[NR];
        item_t         it;
        reset_dut();
        model_ptr = 0;
        sb.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                ra[i] = AW'($urandom);
                rb[i] = BW'({$urandom, $urandom, $urandom});
                set_op(i, ra[i], rb[i]);
            end
            if (cyc < 390) begin
                req_valid = NR'($urandom);
                rsp_ready = NR'($urandom);
            end else begin
                req_valid = '0;
                rsp_ready = '1;
            end
            #1;
            s2_full = (sb.size() > 0) && (sb[0].stage == 2);
            s1_full = 1'b0;
            foreach (sb[j]) if (sb[j].stage == 1) s1_full = 1'b1;
            fo      = (sb.size() > 0) ? sb[0].owner : 0;
            adv2m   = !s2_full || rsp_ready[fo];
            adv1m   = !s1_full || adv2m;
            g       = adv1m ? rr_pick(req_valid, model_ptr) : -1;
            n_checks++;
            if (req_ready !== onehot(g)) begin
                n_fail++; $display("[TB] FAIL rand_grant cyc=%0d: got %b expected %b", cyc, req_ready, onehot(g));
            end
            n_checks++;
            if (rsp_valid !== (s2_full ? onehot(fo) : '0)) begin
                n_fail++; $display("[TB] FAIL rand_rsp_valid cyc=%0d: got %b expected %b", cyc, rsp_valid, s2_full ? onehot(fo) : 4'b0000);
            end
            if (s2_full) begin
                n_checks++;
                if (rsp_data !== sb[0].prod) begin
                    n_fail++; $display("[TB] FAIL rand_rsp_data cyc=%0d: got %h expected %h", cyc, rsp_data, sb[0].prod);
                end
            end
            if (s2_full && rsp_ready[fo]) void'(sb.pop_front());
            if (adv2m) begin
                foreach (sb[j]) if (sb[j].stage == 1) sb[j].stage = 2;
            end
            if (g >= 0) begin
                it.owner = g;
                it.prod  = mulp(ra[g], rb[g]);
                it.stage = 1;
                sb.push_back(it);
                model_ptr = (g + 1) % NR;
            end
            step();
        end
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++; $display("[TB] FAIL rand_drain: got %0d outstanding expected 0", sb.size());
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        ap_rst_n  = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_skip();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
